lab3_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the Lab3 turn-signal/hazard light sequencer.
- Synchronizes and debounces the raw direction push-button level and the two mode switches.
- Resolves the debounced inputs into a single prioritized light mode.
- Generates the slow step strobe that advances the downstream light pattern, realigned on every mode change.

---
 rtl/lab3_input_conditioner.sv | 100 ++++++++++
 tb/tb_lab3_input_conditioner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_input_conditioner.sv
// Input front end for the Lab3 light sequencer: synchronizes and debounces KEY[1]/SW[1:0],
// resolves the prioritized light mode and generates the mode-aligned pattern step strobe.
module lab3_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DB_W            = 17,
    parameter int TICK_DIV        = 2500000,
    parameter int TICK_W          = 22
) (
    input  logic       ADC_CLK_10,
    input  logic       KEY0,
    input  logic       key1_raw,
    input  logic [1:0] sw_raw,
    output logic       dir_left,
    output logic       turn_en,
    output logic       hazard_en,
    output logic [1:0] mode,
    output logic       mode_change,
    output logic       step_tick
);

    // Bit order {key1, sw[1], sw[0]}; key idles high (right), switches idle low.
    localparam logic [2:0]        IN_RST    = 3'b100;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [2:0]        sync_q [SYNC_STAGES];
    logic [2:0]        db_q;
    logic [DB_W-1:0]   db_cnt [3];
    logic [TICK_W-1:0] tick_cnt;
    logic [1:0]        next_mode;

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IN_RST;
        end else begin
            sync_q[0] <= {key1_raw, sw_raw};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            db_q <= IN_RST;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_q[SYNC_STAGES-1][i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_q[i]   <= sync_q[SYNC_STAGES-1][i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign dir_left  = ~db_q[2];
    assign turn_en   = db_q[1];
    assign hazard_en = db_q[0];

    always_comb begin
        next_mode = 2'b00;
        if (db_q[0])      next_mode = 2'b11;
        else if (db_q[1]) next_mode = db_q[2] ? 2'b01 : 2'b10;
    end

    // A mode change restarts the step cadence and wins over a coincident wrap.
    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            mode        <= 2'b00;
            mode_change <= 1'b0;
            tick_cnt    <= '0;
            step_tick   <= 1'b0;
        end else begin
            mode <= next_mode;
            if (next_mode != mode) begin
                mode_change <= 1'b1;
                tick_cnt    <= '0;
                step_tick   <= 1'b0;
            end else begin
                mode_change <= 1'b0;
                if (mode == 2'b00) begin
                    tick_cnt  <= '0;
                    step_tick <= 1'b0;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_cnt  <= '0;
                    step_tick <= 1'b1;
                end else begin
                    tick_cnt  <= tick_cnt + TICK_W'(1);
                    step_tick <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lab3_input_conditioner.sv
// Bench for lab3_input_conditioner: directed plan steps plus randomized input levels,
// every edge compared against a history/window based reference of the input rules.
module tb_lab3_input_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int TD   = 8;

    logic       clk = 1'b0;
    logic       KEY0 = 1'b1;
    logic       key1_raw = 1'b1;
    logic [1:0] sw_raw = 2'b11;
    logic       dir_left, turn_en, hazard_en, mode_change, step_tick;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    lab3_input_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .DB_W(3), .TICK_DIV(TD), .TICK_W(3)
    ) dut (
        .ADC_CLK_10 (clk),
        .KEY0       (KEY0),
        .key1_raw   (key1_raw),
        .sw_raw     (sw_raw),
        .dir_left   (dir_left),
        .turn_en    (turn_en),
        .hazard_en  (hazard_en),
        .mode       (mode),
        .mode_change(mode_change),
        .step_tick  (step_tick)
    );

    always #50 clk = ~clk;

    // Reference: raw sample history, window of debouncer-visible samples, cycles since mode change.
    logic [2:0] raw_q[$];
    logic [2:0] seen_q[$];
    logic [2:0] m_db;
    logic [1:0] m_mode;
    logic       m_chg, m_tick;
    int         since, edge_n;

    function automatic logic [1:0] resolve(input logic [2:0] d);
        if (d[0]) return 2'b11;
        if (d[1]) return d[2] ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        raw_q.delete();
        seen_q.delete();
        for (int i = 0; i < SYNC; i++) raw_q.push_back(3'b100);
        for (int i = 0; i < DB; i++) seen_q.push_back(3'b100);
        m_db = 3'b100; m_mode = 2'b00; m_chg = 1'b0; m_tick = 1'b0;
        since = 0; edge_n = 0;
    endtask

    task automatic model_edge();
        logic [2:0] seen, nd;
        logic [1:0] nm;
        logic       all_diff;
        seen = raw_q[raw_q.size() - SYNC];
        raw_q.push_back({key1_raw, sw_raw});
        if (raw_q.size() > SYNC) void'(raw_q.pop_front());
        seen_q.push_back(seen);
        if (seen_q.size() > DB) void'(seen_q.pop_front());
        nm = resolve(m_db);
        nd = m_db;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            foreach (seen_q[i]) if (seen_q[i][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_db[b];
        end
        if (nm != m_mode) begin
            m_chg = 1'b1; m_tick = 1'b0; since = 0;
        end else begin
            m_chg = 1'b0;
            if (m_mode == 2'b00) begin
                since = 0; m_tick = 1'b0;
            end else begin
                since++;
                m_tick = (since % TD == 0);
            end
        end
        m_mode = nm;
        m_db   = nd;
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dir_left",    {1'b0, dir_left},    {1'b0, ~m_db[2]});
        chk("turn_en",     {1'b0, turn_en},     {1'b0, m_db[1]});
        chk("hazard_en",   {1'b0, hazard_en},   {1'b0, m_db[0]});
        chk("mode",        mode,                m_mode);
        chk("mode_change", {1'b0, mode_change}, {1'b0, m_chg});
        chk("step_tick",   {1'b0, step_tick},   {1'b0, m_tick});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!KEY0) model_reset();
        else model_edge();
        check_all();
    endtask

    // Asserts reset between edges and checks the outputs clear without any clock edge.
    task automatic async_reset();
        #10;
        KEY0 = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic wait_for(input int sel, input int max_edges, output int n);
        logic hit;
        n = -1;
        hit = 1'b0;
        for (int i = 1; i <= max_edges && !hit; i++) begin
            step();
            case (sel)
                0:       hit = (turn_en === 1'b1);
                1:       hit = (mode_change === 1'b1);
                default: hit = (step_tick === 1'b1);
            endcase
            if (hit) n = i;
        end
    endtask

    int n, cnt, hold;

    initial begin
        // 1: reset while the switches request hazard
        #20;
        KEY0 = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) step();

        // 2: right turn from release
        sw_raw = 2'b10; key1_raw = 1'b1;
        #10;
        KEY0 = 1'b1;
        wait_for(0, 20, n); chk_n("turn_en_edge", n, 6);
        wait_for(1, 20, n); chk_n("right_mode_change_edge", edge_n, 7);
        chk("right_mode", mode, 2'b01);
        wait_for(2, 20, n); chk_n("tick1_edge", edge_n, 15);
        wait_for(2, 20, n); chk_n("tick2_edge", edge_n, 23);
        wait_for(2, 20, n); chk_n("tick3_edge", edge_n, 31);

        // 3: 3-cycle hazard glitch is rejected and the cadence continues
        cnt = 0;
        sw_raw = 2'b11;
        repeat (3) begin step(); cnt += int'(mode_change) + int'(hazard_en); end
        sw_raw = 2'b10;
        repeat (6) begin step(); cnt += int'(mode_change) + int'(hazard_en); end
        chk_n("glitch_side_effects", cnt, 0);
        chk_n("glitch_tick_edge", edge_n, 40);
        wait_for(2, 20, n); chk_n("glitch_next_tick_edge", edge_n, 47);

        // 4: left, then hazard, then direction toggles under hazard
        key1_raw = 1'b0;
        wait_for(1, 20, n); chk_n("left_change_latency", n, 7);
        chk("left_mode", mode, 2'b10);
        wait_for(2, 20, n); chk_n("left_first_tick", n, 8);
        sw_raw = 2'b11;
        wait_for(1, 20, n); chk_n("hazard_change_latency", n, 7);
        chk("hazard_mode", mode, 2'b11);
        cnt = 0;
        key1_raw = 1'b1;
        repeat (10) begin step(); cnt += int'(mode_change); end
        key1_raw = 1'b0;
        repeat (10) begin step(); cnt += int'(mode_change); end
        chk_n("hazard_dir_toggle_changes", cnt, 0);

        // 5: off
        sw_raw = 2'b00;
        wait_for(1, 20, n); chk_n("off_change_latency", n, 7);
        chk("off_mode", mode, 2'b00);
        cnt = 0;
        repeat (20) begin step(); cnt += int'(step_tick); end
        chk_n("off_ticks", cnt, 0);

        // 6: reset while in hazard with the tick counter at 5
        sw_raw = 2'b01;
        wait_for(1, 20, n); chk_n("hazard2_change_latency", n, 7);
        cnt = 0;
        while (since % TD != 5 && cnt < 20) begin step(); cnt++; end
        chk_n("tick_phase_reached", since % TD, 5);
        async_reset();
        repeat (2) step();
        #10;
        KEY0 = 1'b1;
        wait_for(1, 20, n); chk_n("post_reset_change_edge", n, 7);
        chk("post_reset_mode", mode, 2'b11);
        wait_for(2, 20, n); chk_n("post_reset_first_tick", n, 8);

        // Randomized input levels with occasional resets
        for (int r = 0; r < 60; r++) begin
            key1_raw = 1'($urandom_range(0, 1));
            sw_raw   = 2'($urandom_range(0, 3));
            hold     = $urandom_range(1, 12);
            repeat (hold) step();
            if ($urandom_range(0, 14) == 0) begin
                async_reset();
                repeat ($urandom_range(0, 2)) step();
                #10;
                KEY0 = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
